// File: rtl/lab2_proc_mem_responder.sv
// Word-organised memory responder for a val/rdy request/response stream pair, 1-cycle latency, 2-entry response FIFO.
// Optional range/alignment error responses are enabled by defining LAB2_PROC_MEM_RESPONDER_ERR_EN.
module lab2_proc_mem_responder #(
    parameter int unsigned p_mem_nwords = 256,
    parameter logic [31:0] p_base_addr  = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        reqstream_val,
    output logic        reqstream_rdy,
    input  logic [76:0] reqstream_msg,
    output logic        respstream_val,
    input  logic        respstream_rdy,
    output logic [46:0] respstream_msg
);

    localparam int unsigned idx_w = $clog2(p_mem_nwords);

    typedef enum logic [2:0] {
        MEM_READ       = 3'd0,
        MEM_WRITE      = 3'd1,
        MEM_WRITE_INIT = 3'd2
    } mem_type_e;

    logic [31:0] mem [p_mem_nwords];

    logic [2:0]  req_type;
    logic [7:0]  req_opaque;
    logic [31:0] req_addr;
    logic [1:0]  req_len;
    logic [31:0] req_data;

    assign req_type   = reqstream_msg[76:74];
    assign req_opaque = reqstream_msg[73:66];
    assign req_addr   = reqstream_msg[65:34];
    assign req_len    = reqstream_msg[33:32];
    assign req_data   = reqstream_msg[31:0];

    logic [31:0]      offset;
    logic [idx_w-1:0] word_idx;
    logic [1:0]       byte_off;
    logic             is_read;
    logic             is_write;
    logic             access_ok;
    logic [1:0]       resp_test;

    assign offset   = req_addr - p_base_addr;
    assign word_idx = offset[idx_w+1:2];
    assign byte_off = offset[1:0];
    assign is_read  = (req_type == MEM_READ);
    assign is_write = (req_type == MEM_WRITE) || (req_type == MEM_WRITE_INIT);

`ifdef LAB2_PROC_MEM_RESPONDER_ERR_EN
    localparam logic [32:0] mem_bytes = 33'(4 * p_mem_nwords);
    logic out_of_range;
    logic misaligned;
    assign out_of_range = ({1'b0, offset} >= mem_bytes);
    assign misaligned   = (req_len == 2'd0) && (byte_off != 2'd0);
    assign access_ok    = !out_of_range && !misaligned;
    assign resp_test    = out_of_range ? 2'b01 : (misaligned ? 2'b11 : 2'b00);
`else
    // Upper offset bits are discarded: addresses wrap modulo the memory size.
    logic unused_offset_hi;
    assign unused_offset_hi = ^offset[31:idx_w+2];
    assign access_ok        = 1'b1;
    assign resp_test        = 2'b00;
`endif

    logic [31:0] rd_word;
    logic [31:0] rd_shifted;
    logic [31:0] rd_data;

    assign rd_word    = mem[word_idx];
    assign rd_shifted = rd_word >> {byte_off, 3'b000};

    always_comb begin
        rd_data = rd_shifted;
        case (req_len)
            2'd1:    rd_data = {24'h0, rd_shifted[7:0]};
            2'd2:    rd_data = {16'h0, rd_shifted[15:0]};
            2'd3:    rd_data = {8'h0, rd_shifted[23:0]};
            default: rd_data = rd_shifted;
        endcase
    end

    logic [3:0]  wr_be;
    logic [31:0] wr_bytes;

    // Request byte k lands on lane byte_off+k; lanes beyond 3 simply never match.
    always_comb begin
        int unsigned nbytes;
        wr_be    = '0;
        wr_bytes = '0;
        nbytes   = (req_len == 2'd0) ? 32'd4 : 32'(req_len);
        for (int unsigned lane = 0; lane < 4; lane++) begin
            if (lane >= 32'(byte_off) && (lane - 32'(byte_off)) < nbytes) begin
                wr_be[lane]          = 1'b1;
                wr_bytes[8*lane +: 8] = req_data[8*(lane - 32'(byte_off)) +: 8];
            end
        end
    end

    logic [31:0] resp_data;
    logic [46:0] resp_entry;

    always_comb begin
        resp_data = '0;
        if (!access_ok)
            resp_data = 32'hdeadbeef;
        else if (is_read)
            resp_data = rd_data;
    end

    assign resp_entry = {req_type, req_opaque, resp_test, req_len, resp_data};

    logic [46:0] fifo [2];
    logic        head;
    logic [1:0]  count;
    logic        tail;
    logic        req_fire;
    logic        resp_fire;

    assign tail           = head ^ count[0];
    assign reqstream_rdy  = (count != 2'd2);
    assign respstream_val = (count != 2'd0);
    assign respstream_msg = respstream_val ? fifo[head] : '0;
    assign req_fire       = reqstream_val && reqstream_rdy;
    assign resp_fire      = respstream_val && respstream_rdy;

    always_ff @(posedge clk) begin
        if (!reset && req_fire && is_write && access_ok) begin
            for (int unsigned lane = 0; lane < 4; lane++) begin
                if (wr_be[lane])
                    mem[word_idx][8*lane +: 8] <= wr_bytes[8*lane +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head  <= 1'b0;
            count <= 2'd0;
        end else begin
            if (req_fire)
                fifo[tail] <= resp_entry;
            if (resp_fire)
                head <= ~head;
            case ({req_fire, resp_fire})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_lab2_proc_mem_responder.sv
// Directed self-checking bench for lab2_proc_mem_responder (default 256-word, base 0 configuration).
module tb_lab2_proc_mem_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_val = 1'b0;
    logic        req_rdy;
    logic [76:0] req_msg = '0;
    logic        resp_val;
    logic        resp_rdy = 1'b0;
    logic [46:0] resp_msg;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    lab2_proc_mem_responder #(
        .p_mem_nwords(256),
        .p_base_addr (32'h0)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .reqstream_val (req_val),
        .reqstream_rdy (req_rdy),
        .reqstream_msg (req_msg),
        .respstream_val(resp_val),
        .respstream_rdy(resp_rdy),
        .respstream_msg(resp_msg)
    );

    function automatic logic [46:0] mk_resp(input logic [2:0] t, input logic [7:0] o,
                                            input logic [1:0] tst, input logic [1:0] l,
                                            input logic [31:0] d);
        return {t, o, tst, l, d};
    endfunction

    // Called at a negedge; returns at the negedge right after the request fires.
    task automatic do_req(input logic [2:0] t, input logic [7:0] o, input logic [31:0] a,
                          input logic [1:0] l, input logic [31:0] d);
        bit fired = 1'b0;
        req_val = 1'b1;
        req_msg = {t, o, a, l, d};
        for (int i = 0; i < 20 && !fired; i++) begin
            if (req_rdy) fired = 1'b1;
            @(negedge clk);
        end
        req_val = 1'b0;
        tests++;
        if (!fired) begin
            fails++;
            $display("FAIL req_fire_timeout: type %0d addr %h not accepted within 20 cycles", t, a);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        tests++;
        if (resp_val !== 1'b0) begin fails++; $display("FAIL reset_resp_val: got %b want 0", resp_val); end
        tests++;
        if (req_rdy !== 1'b1) begin fails++; $display("FAIL reset_req_rdy: got %b want 1", req_rdy); end
        tests++;
        if (resp_msg !== 47'h0) begin fails++; $display("FAIL reset_resp_msg: got %h want 0", resp_msg); end
    endtask

    task automatic test_write_read();
        logic [46:0] exp;
        resp_rdy = 1'b1;
        do_req(3'd1, 8'd3, 32'h10, 2'd0, 32'hcafef00d);
        exp = mk_resp(3'd1, 8'd3, 2'b00, 2'd0, 32'h0);
        tests++;
        if (resp_val !== 1'b1 || resp_msg !== exp) begin
            fails++; $display("FAIL wr_resp: val %b msg %h want val 1 msg %h", resp_val, resp_msg, exp);
        end
        do_req(3'd0, 8'd4, 32'h10, 2'd0, 32'h0);
        exp = mk_resp(3'd0, 8'd4, 2'b00, 2'd0, 32'hcafef00d);
        tests++;
        if (resp_val !== 1'b1 || resp_msg !== exp) begin
            fails++; $display("FAIL rd_after_wr: val %b msg %h want val 1 msg %h", resp_val, resp_msg, exp);
        end
        @(negedge clk);
        tests++;
        if (resp_val !== 1'b0) begin fails++; $display("FAIL wr_rd_drain: resp_val %b want 0", resp_val); end
    endtask

    task automatic test_subword();
        logic [46:0] exp;
        resp_rdy = 1'b1;
        do_req(3'd1, 8'd1, 32'h20, 2'd0, 32'h11223344);
        do_req(3'd1, 8'd2, 32'h21, 2'd1, 32'h000000aa);
        exp = mk_resp(3'd1, 8'd2, 2'b00, 2'd1, 32'h0);
        tests++;
        if (resp_msg !== exp) begin fails++; $display("FAIL sub_wr_resp: got %h want %h", resp_msg, exp); end
        do_req(3'd0, 8'd3, 32'h22, 2'd2, 32'h0);
        exp = mk_resp(3'd0, 8'd3, 2'b00, 2'd2, 32'h00001122);
        tests++;
        if (resp_msg !== exp) begin fails++; $display("FAIL sub_rd_len2: got %h want %h", resp_msg, exp); end
        do_req(3'd0, 8'd4, 32'h20, 2'd0, 32'h0);
        exp = mk_resp(3'd0, 8'd4, 2'b00, 2'd0, 32'h1122aa44);
        tests++;
        if (resp_msg !== exp) begin fails++; $display("FAIL sub_rd_full: got %h want %h", resp_msg, exp); end
        do_req(3'd0, 8'd5, 32'h23, 2'd1, 32'h0);
        exp = mk_resp(3'd0, 8'd5, 2'b00, 2'd1, 32'h00000011);
        tests++;
        if (resp_msg !== exp) begin fails++; $display("FAIL sub_rd_len1: got %h want %h", resp_msg, exp); end
        @(negedge clk);
    endtask

    task automatic test_types();
        logic [46:0] exp;
        resp_rdy = 1'b1;
        do_req(3'd2, 8'd6, 32'h30, 2'd0, 32'h55667788);
        exp = mk_resp(3'd2, 8'd6, 2'b00, 2'd0, 32'h0);
        tests++;
        if (resp_msg !== exp) begin fails++; $display("FAIL winit_resp: got %h want %h", resp_msg, exp); end
        do_req(3'd1, 8'd7, 32'h33, 2'd2, 32'h0000bbee);
        exp = mk_resp(3'd1, 8'd7, 2'b00, 2'd2, 32'h0);
        tests++;
        if (resp_msg !== exp) begin fails++; $display("FAIL lane_drop_wr_resp: got %h want %h", resp_msg, exp); end
        do_req(3'd0, 8'd8, 32'h30, 2'd0, 32'h0);
        exp = mk_resp(3'd0, 8'd8, 2'b00, 2'd0, 32'hee667788);
        tests++;
        if (resp_msg !== exp) begin fails++; $display("FAIL lane_drop_rd: got %h want %h", resp_msg, exp); end
        do_req(3'd5, 8'd9, 32'h30, 2'd0, 32'hffffffff);
        exp = mk_resp(3'd5, 8'd9, 2'b00, 2'd0, 32'h0);
        tests++;
        if (resp_msg !== exp) begin fails++; $display("FAIL other_type_resp: got %h want %h", resp_msg, exp); end
        do_req(3'd0, 8'd10, 32'h30, 2'd0, 32'h0);
        exp = mk_resp(3'd0, 8'd10, 2'b00, 2'd0, 32'hee667788);
        tests++;
        if (resp_msg !== exp) begin fails++; $display("FAIL other_type_no_write: got %h want %h", resp_msg, exp); end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        logic [46:0] exp;
        resp_rdy = 1'b0;
        req_val  = 1'b1;
        req_msg  = {3'd0, 8'd10, 32'h10, 2'd0, 32'h0};
        tests++;
        if (req_rdy !== 1'b1) begin fails++; $display("FAIL bp_rdy_c0: got %b want 1", req_rdy); end
        @(negedge clk);
        tests++;
        if (req_rdy !== 1'b1 || resp_val !== 1'b1) begin
            fails++; $display("FAIL bp_c1: rdy %b val %b want 1 1", req_rdy, resp_val);
        end
        req_msg = {3'd0, 8'd11, 32'h20, 2'd0, 32'h0};
        @(negedge clk);
        tests++;
        if (req_rdy !== 1'b0) begin fails++; $display("FAIL bp_full_rdy: got %b want 0", req_rdy); end
        req_msg = {3'd0, 8'd12, 32'h30, 2'd0, 32'h0};
        @(negedge clk);
        exp = mk_resp(3'd0, 8'd10, 2'b00, 2'd0, 32'hcafef00d);
        tests++;
        if (req_rdy !== 1'b0 || resp_msg !== exp) begin
            fails++; $display("FAIL bp_hold: rdy %b msg %h want rdy 0 msg %h", req_rdy, resp_msg, exp);
        end
        resp_rdy = 1'b1;
        @(negedge clk);
        exp = mk_resp(3'd0, 8'd11, 2'b00, 2'd0, 32'h1122aa44);
        tests++;
        if (req_rdy !== 1'b1 || resp_msg !== exp) begin
            fails++; $display("FAIL bp_second: rdy %b msg %h want rdy 1 msg %h", req_rdy, resp_msg, exp);
        end
        @(negedge clk);
        req_val = 1'b0;
        exp = mk_resp(3'd0, 8'd12, 2'b00, 2'd0, 32'hee667788);
        tests++;
        if (resp_val !== 1'b1 || resp_msg !== exp) begin
            fails++; $display("FAIL bp_third: val %b msg %h want val 1 msg %h", resp_val, resp_msg, exp);
        end
        @(negedge clk);
        tests++;
        if (resp_val !== 1'b0) begin fails++; $display("FAIL bp_drain: resp_val %b want 0", resp_val); end
    endtask

    task automatic test_back_to_back();
        logic [46:0] exp;
        resp_rdy = 1'b1;
        req_val  = 1'b1;
        for (int k = 0; k < 16; k++) begin
            req_msg = {3'd0, 8'(k), 32'h20, 2'd0, 32'h0};
            tests++;
            if (req_rdy !== 1'b1) begin fails++; $display("FAIL b2b_rdy[%0d]: got %b want 1", k, req_rdy); end
            if (k > 0) begin
                exp = mk_resp(3'd0, 8'(k - 1), 2'b00, 2'd0, 32'h1122aa44);
                tests++;
                if (resp_val !== 1'b1 || resp_msg !== exp) begin
                    fails++; $display("FAIL b2b_resp[%0d]: val %b msg %h want %h", k - 1, resp_val, resp_msg, exp);
                end
            end
            @(negedge clk);
        end
        req_val = 1'b0;
        exp = mk_resp(3'd0, 8'd15, 2'b00, 2'd0, 32'h1122aa44);
        tests++;
        if (resp_val !== 1'b1 || resp_msg !== exp) begin
            fails++; $display("FAIL b2b_last: val %b msg %h want %h", resp_val, resp_msg, exp);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic [46:0] exp;
        resp_rdy = 1'b0;
        do_req(3'd0, 8'd20, 32'h10, 2'd0, 32'h0);
        do_req(3'd0, 8'd21, 32'h20, 2'd0, 32'h0);
        tests++;
        if (req_rdy !== 1'b0 || resp_val !== 1'b1) begin
            fails++; $display("FAIL rst_mid_full: rdy %b val %b want 0 1", req_rdy, resp_val);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        tests++;
        if (resp_val !== 1'b0 || req_rdy !== 1'b1) begin
            fails++; $display("FAIL rst_mid_flush: val %b rdy %b want 0 1", resp_val, req_rdy);
        end
        resp_rdy = 1'b1;
        do_req(3'd0, 8'd22, 32'h10, 2'd0, 32'h0);
        exp = mk_resp(3'd0, 8'd22, 2'b00, 2'd0, 32'hcafef00d);
        tests++;
        if (resp_msg !== exp) begin fails++; $display("FAIL rst_mid_persist: got %h want %h", resp_msg, exp); end
        @(negedge clk);
    endtask

    task automatic test_range();
        logic [46:0] exp;
        resp_rdy = 1'b1;
        do_req(3'd1, 8'd30, 32'h0, 2'd0, 32'h0badf00d);
        do_req(3'd0, 8'd31, 32'h400, 2'd0, 32'h0);
`ifdef LAB2_PROC_MEM_RESPONDER_ERR_EN
        exp = mk_resp(3'd0, 8'd31, 2'b01, 2'd0, 32'hdeadbeef);
`else
        exp = mk_resp(3'd0, 8'd31, 2'b00, 2'd0, 32'h0badf00d);
`endif
        tests++;
        if (resp_msg !== exp) begin fails++; $display("FAIL range_rd: got %h want %h", resp_msg, exp); end
        do_req(3'd0, 8'd32, 32'h410, 2'd0, 32'h0);
`ifdef LAB2_PROC_MEM_RESPONDER_ERR_EN
        exp = mk_resp(3'd0, 8'd32, 2'b01, 2'd0, 32'hdeadbeef);
`else
        exp = mk_resp(3'd0, 8'd32, 2'b00, 2'd0, 32'hcafef00d);
`endif
        tests++;
        if (resp_msg !== exp) begin fails++; $display("FAIL wrap_rd: got %h want %h", resp_msg, exp); end
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_write_read();
        test_subword();
        test_types();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_range();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, tests %0d failed %0d", tests, fails);
        $fatal(1, "watchdog");
    end

endmodule
